// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - multicycle sequencer around the mulxx multiplier/shifter
// Optional multiply-accumulate mode: define MUL_SEQ_ACC_EN
module mul_seq #(
    parameter int WORD_SIZE  = 18,
    parameter int MUL_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [4:0]           shift,
    input  logic                 signx,
    input  logic                 signy,
    input  logic [2:0]           dst,
`ifdef MUL_SEQ_ACC_EN
    input  logic                 acc,
    input  logic                 acc_clr,
`endif
    output logic                 busy,
    output logic [WORD_SIZE-1:0] mx_r0,
    output logic [WORD_SIZE-1:0] mx_r1,
    output logic [4:0]           mx_shift,
    output logic                 mx_signx,
    output logic                 mx_signy,
    input  logic [WORD_SIZE-1:0] mx_res,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [WORD_SIZE-1:0] wb_data,
    output logic [2:0]           wb_dst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cnt;

`ifdef MUL_SEQ_ACC_EN
    logic                 acc_op;
    logic [WORD_SIZE-1:0] acc_q;
    logic [WORD_SIZE-1:0] capture;
    assign capture = acc_op ? mx_res + acc_q : mx_res;
`else
    logic [WORD_SIZE-1:0] capture;
    assign capture = mx_res;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            busy     <= 1'b0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_dst   <= 3'd0;
            mx_r0    <= '0;
            mx_r1    <= '0;
            mx_shift <= 5'd0;
            mx_signx <= 1'b0;
            mx_signy <= 1'b0;
`ifdef MUL_SEQ_ACC_EN
            acc_op   <= 1'b0;
            acc_q    <= '0;
`endif
        end else begin
            if (flush) begin
                // mx_* keep their values; only the sequencing and the result are dropped
                state    <= S_IDLE;
                busy     <= 1'b0;
                wb_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            mx_r0    <= a;
                            mx_r1    <= b;
                            mx_shift <= shift;
                            mx_signx <= signx;
                            mx_signy <= signy;
                            wb_dst   <= dst;
`ifdef MUL_SEQ_ACC_EN
                            acc_op   <= acc;
`endif
                            cnt      <= 3'(MUL_CYCLES - 1);
                            busy     <= 1'b1;
                            state    <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == 3'd0) begin
                            wb_data  <= capture;
                            wb_valid <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    S_DONE: begin
                        if (wb_ready) begin
                            wb_valid <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        busy     <= 1'b0;
                        wb_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                endcase
            end
`ifdef MUL_SEQ_ACC_EN
            // clear wins over the handshake load on the same edge
            if (acc_clr)
                acc_q <= '0;
            else if (state == S_DONE && wb_ready && !flush)
                acc_q <= wb_data;
`endif
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - directed self-checking bench for mul_seq with a behavioural mulxx
module tb_mul_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        flush;
    logic [17:0] a;
    logic [17:0] b;
    logic [4:0]  shift;
    logic        signx;
    logic        signy;
    logic [2:0]  dst;
`ifdef MUL_SEQ_ACC_EN
    logic        acc;
    logic        acc_clr;
`endif
    logic        busy;
    logic [17:0] mx_r0;
    logic [17:0] mx_r1;
    logic [4:0]  mx_shift;
    logic        mx_signx;
    logic        mx_signy;
    logic [17:0] mx_res;
    logic        wb_valid;
    logic        wb_ready;
    logic [17:0] wb_data;
    logic [2:0]  wb_dst;

    int n_cmp;
    int n_err;
    int hs_count;
    int hs_base;

    mul_seq #(.WORD_SIZE(18), .MUL_CYCLES(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .shift    (shift),
        .signx    (signx),
        .signy    (signy),
        .dst      (dst),
`ifdef MUL_SEQ_ACC_EN
        .acc      (acc),
        .acc_clr  (acc_clr),
`endif
        .busy     (busy),
        .mx_r0    (mx_r0),
        .mx_r1    (mx_r1),
        .mx_shift (mx_shift),
        .mx_signx (mx_signx),
        .mx_signy (mx_signy),
        .mx_res   (mx_res),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_data  (wb_data),
        .wb_dst   (wb_dst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // mulxx: signed/unsigned 36-bit product, logical right shift, low 18 bits
    logic signed [18:0] ext_x;
    logic signed [18:0] ext_y;
    logic signed [37:0] prod;
    logic [35:0]        prod36;
    always_comb begin
        ext_x  = {mx_signx & mx_r0[17], mx_r0};
        ext_y  = {mx_signy & mx_r1[17], mx_r1};
        prod   = 38'(ext_x) * 38'(ext_y);
        prod36 = prod[35:0] >> mx_shift;
        mx_res = prod36[17:0];
    end

    always @(posedge clock)
        if (reset_n && wb_valid && wb_ready && !flush)
            hs_count <= hs_count + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // accept at E0, then two edges of settling; returns just after E0+2
    task automatic run_op(input logic [17:0] ta, input logic [17:0] tb2, input logic [4:0] ts,
                          input logic tsx, input logic tsy, input logic [2:0] td);
        a = ta; b = tb2; shift = ts; signx = tsx; signy = tsy; dst = td;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 36'(busy), 36'd1);
        tick();
        check("valid_low_mid_wait", 36'(wb_valid), 36'd0);
        tick();
        check("valid_at_latency", 36'(wb_valid), 36'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; hs_count = 0;
        reset_n = 1'b0; start = 1'b0; flush = 1'b0; wb_ready = 1'b0;
        a = '0; b = '0; shift = '0; signx = 1'b0; signy = 1'b0; dst = '0;
`ifdef MUL_SEQ_ACC_EN
        acc = 1'b0; acc_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", 36'(busy), 36'd0);
        check("rst_valid", 36'(wb_valid), 36'd0);
        check("rst_data", 36'(wb_data), 36'd0);
        check("rst_dst", 36'(wb_dst), 36'd0);
        check("rst_mx_r0", 36'(mx_r0), 36'd0);
        reset_n = 1'b1;
        tick();

        // unsigned 3*5
        wb_ready = 1'b1;
        run_op(18'd3, 18'd5, 5'd0, 1'b0, 1'b0, 3'd4);
        check("u_data", 36'(wb_data), 36'd15);
        check("u_dst", 36'(wb_dst), 36'd4);
        tick();
        check("u_valid_drop", 36'(wb_valid), 36'd0);
        check("u_busy_drop", 36'(busy), 36'd0);
        tick();

        // signed -1 * 2
        run_op(18'h3FFFF, 18'd2, 5'd0, 1'b1, 1'b1, 3'd1);
        check("s_neg_data", 36'(wb_data), 36'h3FFFE);
        tick();
        tick();

        // signed min*min >> 17
        run_op(18'h20000, 18'h20000, 5'd17, 1'b1, 1'b1, 3'd2);
        check("s_min_data", 36'(wb_data), 36'h20000);
        tick();
        tick();

        // backpressure with a start pulse that must be ignored
        wb_ready = 1'b0;
        hs_base = hs_count;
        run_op(18'h3FFFF, 18'h3FFFF, 5'd18, 1'b0, 1'b0, 3'd6);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin a = 18'd1; b = 18'd1; start = 1'b1; end
            else start = 1'b0;
            tick();
            check("bp_valid", 36'(wb_valid), 36'd1);
            check("bp_data", 36'(wb_data), 36'h3FFFE);
        end
        start = 1'b0;
        check("bp_mx_hold", 36'(mx_r0), 36'h3FFFF);
        check("bp_dst", 36'(wb_dst), 36'd6);
        wb_ready = 1'b1;
        tick();
        check("bp_valid_drop", 36'(wb_valid), 36'd0);
        tick();
        tick();
        tick();
        check("bp_no_second_op", 36'(busy), 36'd0);
        check("bp_one_handshake", 36'(hs_count - hs_base), 36'd1);

        // flush in the first WAIT cycle
        hs_base = hs_count;
        a = 18'd7; b = 18'd7; shift = 5'd0; signx = 1'b0; signy = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", 36'(busy), 36'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_valid_never", 36'(wb_valid), 36'd0);
        end
        check("fl_no_handshake", 36'(hs_count - hs_base), 36'd0);

        // flush and start together in IDLE
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        check("fs_not_accepted", 36'(busy), 36'd0);
        tick();
        tick();
        check("fs_no_valid", 36'(wb_valid), 36'd0);

        // reset while in DONE
        wb_ready = 1'b0;
        run_op(18'd7, 18'd9, 5'd3, 1'b0, 1'b0, 3'd5);
        check("rd_data", 36'(wb_data), 36'd7);
        reset_n = 1'b0;
        tick();
        check("rd_busy", 36'(busy), 36'd0);
        check("rd_valid", 36'(wb_valid), 36'd0);
        check("rd_data0", 36'(wb_data), 36'd0);
        check("rd_dst0", 36'(wb_dst), 36'd0);
        check("rd_mx", 36'({mx_r0, mx_r1, mx_shift, mx_signx, mx_signy}), 36'd0);
        reset_n = 1'b1;
        tick();

        // flush together with wb_ready in DONE
        hs_base = hs_count;
        run_op(18'd2, 18'd2, 5'd0, 1'b0, 1'b0, 3'd3);
        flush = 1'b1; wb_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("fd_valid", 36'(wb_valid), 36'd0);
        check("fd_busy", 36'(busy), 36'd0);
        check("fd_no_commit", 36'(hs_count - hs_base), 36'd0);
        tick();

`ifdef MUL_SEQ_ACC_EN
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        acc = 1'b1;
        wb_ready = 1'b1;
        run_op(18'd2, 18'd3, 5'd0, 1'b0, 1'b0, 3'd0);
        check("acc_first", 36'(wb_data), 36'd6);
        tick();
        tick();
        run_op(18'd4, 18'd5, 5'd0, 1'b0, 1'b0, 3'd0);
        check("acc_second", 36'(wb_data), 36'd26);
        tick();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        run_op(18'd1, 18'd1, 5'd0, 1'b0, 1'b0, 3'd0);
        check("acc_after_clr", 36'(wb_data), 36'd1);
        tick();
        acc = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequencing stage that feeds the combinational 18-bit multiplier/shifter (`mulxx`) and consumes its result. It accepts one multiply request from decode, holds the operands stable on the multiplier inputs for a fixed multicycle settling window, captures the product, and presents it to register-file writeback with a valid/ready handshake. This keeps the long multiply path off the single-cycle critical path of the asm18 core.

## Interface
Parameters:
- `WORD_SIZE`, 18, operand and result width.
- `MUL_CYCLES`, 2, cycles allowed for the `mulxx` path to settle; legal range is 1..7.

Ports:
- `clock`  in  1  system clock. All logic is rising-edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request strobe; sampled only while `busy`=0.
- `flush`  in  1  synchronous cancel of any in-flight operation.
- `a`, `b`  in  WORD_SIZE  operands.
- `shift`  in  5  right-shift amount applied to the 36-bit product.
- `signx`, `signy`  in  1  treat `a` / `b` as signed.
- `dst`  in  3  destination register index, passed through unchanged.
- `busy`  out  1  high in any state other than IDLE.
- `mx_r0`, `mx_r1`  out  WORD_SIZE  registered operands to `mulxx`.
- `mx_shift`  out  5; `mx_signx`, `mx_signy`  out  1  registered controls to `mulxx`.
- `mx_res`  in  WORD_SIZE  result from `mulxx`.
- `wb_valid`  out  1  result available.
- `wb_ready`  in  1  writeback accepts the result.
- `wb_data`  out  WORD_SIZE  captured result.
- `wb_dst`  out  3  captured destination index.

## Operation
- FSM states:
  - IDLE: waits for a request.
  - WAIT: counts down the settling window.
  - DONE: holds the result until writeback accepts it.
- Reset (`reset_n`=0 at an edge):
  - State goes to IDLE.
  - All outputs and registers go to 0: `busy`, `wb_valid`, `wb_data`, `wb_dst`, `mx_*`, counter.
  - Reset mid-operation discards the operation with no writeback.
- IDLE, `start`=1, `flush`=0:
  - Latch `a`, `b`, `shift`, `signx`, `signy` into the `mx_*` registers and `dst` into `wb_dst`.
  - Load counter with MUL_CYCLES-1 and go to WAIT.
- WAIT:
  - If counter is 0: capture `mx_res` into `wb_data` and go to DONE.
  - Otherwise decrement the counter.
  - `mx_*` stay constant throughout.
- DONE:
  - `wb_valid`=1; `wb_data` and `wb_dst` are stable.
  - On an edge with `wb_ready`=1, go to IDLE.
- `start` while `busy`=1 is ignored: no queueing and no error.
- `flush`=1 at an edge:
  - Go to IDLE from any state and drop the result; `wb_valid` falls.
  - `flush` has priority over `start`, so a simultaneous `start` in IDLE is not accepted.
  - `flush` in DONE together with `wb_ready` counts as a flush. Writeback must not commit on that edge; it qualifies commit with `!flush`.
- `mx_*` hold their last values in IDLE. They are not cleared, to save toggles.
- Arithmetic is defined entirely by `mulxx`: full 36-bit product, logical right shift by `shift` (0..31), low WORD_SIZE bits kept. `shift` values 18..31 are forwarded unmodified.

## Timing
- Accepting edge E0: `busy` rises after E0.
- `wb_valid` rises after edge E0+MUL_CYCLES. For the default value 2, that is visible in the 3rd cycle after the request cycle.
- `wb_valid` stays high until the edge where `wb_ready`=1. `busy` falls after that same edge.
- Next `start` can be accepted in the following cycle, so there is a one-cycle IDLE bubble between back-to-back ops.
- Minimum issue interval is MUL_CYCLES+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MUL_SEQ_ACC_EN` defined (multiply-accumulate mode):
  - Adds input ports `acc` (1) and `acc_clr` (1) and an internal WORD_SIZE accumulator, reset to 0.
  - `acc` is latched at accept. With `acc`=1, the capture in WAIT is `wb_data` = `mx_res` + accumulator, wrapping mod 2^WORD_SIZE.
  - The accumulator is loaded with `wb_data` on the writeback handshake edge for every op, whether `acc` is 0 or 1.
  - `acc_clr`=1 at any edge zeroes the accumulator. It has priority over a same-edge handshake load.
  - `flush` does not modify the accumulator.
- Not defined: the `acc` and `acc_clr` ports and the accumulator are absent, and `wb_data` = `mx_res`.

## Test plan
- Unsigned: `a`=3, `b`=5, `shift`=0, signs 0, `dst`=4, `wb_ready`=1 → `wb_valid` 2 cycles after accept, `wb_data`=15, `wb_dst`=4.
- Signed product and shift:
  - `a`=0x3FFFF, `b`=2, `signx`=`signy`=1, `shift`=0 → `wb_data`=0x3FFFE.
  - `a`=`b`=0x20000 signed, `shift`=17 → 0x20000.
- Backpressure: `a`=`b`=0x3FFFF unsigned, `shift`=18, `wb_ready` held low 5 cycles with `start` pulsed meanwhile → `wb_data`=0x3FFFE stable, extra start ignored, exactly one handshake.
- Flush and reset:
  - `flush` in the 1st WAIT cycle → IDLE next cycle, `wb_valid` never rises.
  - `reset_n`=0 in DONE → all outputs 0 next cycle.
  - `flush`+`start` together in IDLE → not accepted.
- `MUL_SEQ_ACC_EN`: accept 2×3 with `acc`=1, then 4×5 with `acc`=1 → `wb_data` 6 then 26. After `acc_clr`, 1×1 with `acc`=1 → 1.
